// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//
// Multi-cycle shift-add multiplier controller that borrows a single-cycle ALU.
// While idle the ALU belongs to the external requester (transparent mux).
// On start the controller takes the ALU and runs one ADD per multiplier bit.
// It then returns the low WIDTH bits of mul_a*mul_b on product with a
// one-cycle done pulse.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   start               : multiply request, sampled only in IDLE
//   mul_a, mul_b        : multiplicand / multiplier
//   busy                : high in RUN and DONE
//   done                : one-cycle pulse, product valid
//   product             : low WIDTH bits of the product, held until overwritten
//   ext_a, ext_b, ext_f : requester's ALU operands and function
//   ext_grant           : high in IDLE only; ext_* are then driving the ALU
//   ext_y, ext_zero     : ALU results forwarded unconditionally to requester
//   alu_a, alu_b, alu_f : to the ALU instance
//   alu_y, alu_zero     : from the ALU instance
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    input  logic [WIDTH-1:0] ext_a,
    input  logic [WIDTH-1:0] ext_b,
    input  logic [2:0]       ext_f,
    output logic             ext_grant,
    output logic [WIDTH-1:0] ext_y,
    output logic             ext_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [2:0]       F_ADD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;       // partial product accumulator
    logic [WIDTH-1:0] m_q, m_d;       // multiplicand, shifted left each step
    logic [WIDTH-1:0] q_q, q_d;       // remaining multiplier, shifted right
    logic [CNT_W-1:0] cnt_q, cnt_d;   // iteration counter
    logic [WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0] q_shift_s;      // multiplier after this step's shift
    logic [WIDTH-1:0] p_next_s;       // accumulator after this step's add
    logic             last_iter_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            p_q       <= {WIDTH{1'b0}};
            m_q       <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            product_q <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            m_q       <= m_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state and datapath update for the shift-add sequence.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        m_d       = m_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        q_shift_s = q_q >> 1;
        // Only add when the current multiplier bit is set; the ALU is always
        // computing P+M while we own it, so the result is simply selected.
        if (q_q[0]) begin
            p_next_s = alu_y;
        end else begin
            p_next_s = p_q;
        end
        // With early exit, a multiplier with no bits left ends the run even
        // before all WIDTH steps; at least one RUN cycle always occurs.
        if ((cnt_q == CNT_LAST) || (EARLY_EXIT && (q_shift_s == {WIDTH{1'b0}}))) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = mul_a;
                    q_d     = mul_b;
                    p_d     = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                p_d   = p_next_s;
                m_d   = m_q << 1;
                q_d   = q_shift_s;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (last_iter_s) begin
                    // Capture the accumulator including this final step so
                    // product is already valid in the DONE cycle.
                    product_d = p_next_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ALU ownership mux and status decode from the state register.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        ext_grant = (state_q == ST_IDLE);
        product   = product_q;
        ext_y     = alu_y;
        ext_zero  = alu_zero;
        case (state_q)
            ST_IDLE: begin
                alu_a = ext_a;
                alu_b = ext_b;
                alu_f = ext_f;
            end
            default: begin
                alu_a = p_q;
                alu_b = m_q;
                alu_f = F_ADD;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
//
// Directed bench for alu_mul_seq. Two instances share one reset: dut0 with
// EARLY_EXIT=0 and dut1 with EARLY_EXIT=1, each closed around its own
// behavioural ALU (AND/OR/ADD/SUB/SLT encoding on F).
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start0, start1;
    logic [W-1:0] mul_a, mul_b;
    logic [W-1:0] ext_a, ext_b;
    logic [2:0]   ext_f;

    logic         busy0, done0, grant0, ext_zero0, alu_zero0;
    logic [W-1:0] product0, ext_y0, alu_a0, alu_b0, alu_y0;
    logic [2:0]   alu_f0;
    logic         busy1, done1, grant1, ext_zero1, alu_zero1;
    logic [W-1:0] product1, ext_y1, alu_a1, alu_b1, alu_y1;
    logic [2:0]   alu_f1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Reference single-cycle ALU: F[2] inverts B and adds carry-in.
    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [2:0]   f);
        logic [W-1:0] bb;
        logic [W-1:0] s;
        bb = f[2] ? ~b : b;
        s  = a + bb + {{(W-1){1'b0}}, f[2]};
        case (f[1:0])
            2'b00:   return a & bb;
            2'b01:   return a | bb;
            2'b10:   return s;
            default: return {{(W-1){1'b0}}, s[W-1]};
        endcase
    endfunction

    assign alu_y0    = alu_model(alu_a0, alu_b0, alu_f0);
    assign alu_zero0 = (alu_y0 == {W{1'b0}});
    assign alu_y1    = alu_model(alu_a1, alu_b1, alu_f1);
    assign alu_zero1 = (alu_y1 == {W{1'b0}});

    alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .mul_a(mul_a), .mul_b(mul_b),
        .busy(busy0), .done(done0), .product(product0),
        .ext_a(ext_a), .ext_b(ext_b), .ext_f(ext_f),
        .ext_grant(grant0), .ext_y(ext_y0), .ext_zero(ext_zero0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_f(alu_f0),
        .alu_y(alu_y0), .alu_zero(alu_zero0)
    );

    alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mul_a(mul_a), .mul_b(mul_b),
        .busy(busy1), .done(done1), .product(product1),
        .ext_a(ext_a), .ext_b(ext_b), .ext_f(ext_f),
        .ext_grant(grant1), .ext_y(ext_y1), .ext_zero(ext_zero1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_f(alu_f1),
        .alu_y(alu_y1), .alu_zero(alu_zero1)
    );

    // Drives one multiply on the selected instance and records what it saw
    // over a fixed 40-cycle window; cycle 1 is the cycle after the accepting
    // edge. Called #1 after a clock edge with the instance idle.
    task automatic run_mul(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int done_cyc, output int done_cnt, output int busy_cnt,
                           output int own_err, output logic [W-1:0] prod);
        logic bz, dn, gr;
        logic [2:0] f;
        logic [W-1:0] p;
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; own_err = 0; prod = {W{1'bx}};
        mul_a = a; mul_b = b;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (sel) begin bz = busy1; dn = done1; gr = grant1; f = alu_f1; p = product1; end
            else     begin bz = busy0; dn = done0; gr = grant0; f = alu_f0; p = product0; end
            if (bz) busy_cnt++;
            if (gr === bz) own_err++;
            if (bz && (f !== 3'b010)) own_err++;
            if (dn) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
                prod = p;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0)    begin failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
        checks++; if (done0 !== 1'b0)    begin failures++; $display("FAIL reset_done0 got=%b exp=0", done0); end
        checks++; if (grant0 !== 1'b1)   begin failures++; $display("FAIL reset_grant0 got=%b exp=1", grant0); end
        checks++; if (product0 !== 32'h0) begin failures++; $display("FAIL reset_product0 got=%h exp=0", product0); end
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || grant1 !== 1'b1 || product1 !== 32'h0)
            begin failures++; $display("FAIL reset_dut1 got=%b%b%b/%h exp=001/0", busy1, done1, grant1, product1); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        ext_a = 32'd5; ext_b = 32'd5; ext_f = 3'b110;
        #1;
        checks++; if (alu_f0 !== 3'b110) begin failures++; $display("FAIL pass_alu_f got=%b exp=110", alu_f0); end
        checks++; if (alu_a0 !== 32'd5 || alu_b0 !== 32'd5) begin failures++; $display("FAIL pass_alu_ab got=%h/%h exp=5/5", alu_a0, alu_b0); end
        checks++; if (ext_y0 !== 32'd0)  begin failures++; $display("FAIL pass_sub_y got=%h exp=0", ext_y0); end
        checks++; if (ext_zero0 !== 1'b1) begin failures++; $display("FAIL pass_sub_zero got=%b exp=1", ext_zero0); end
        ext_a = 32'd3; ext_b = 32'd9; ext_f = 3'b111;
        #1;
        checks++; if (ext_y0 !== 32'd1)  begin failures++; $display("FAIL pass_slt_y got=%h exp=1", ext_y0); end
        checks++; if (ext_zero0 !== 1'b0) begin failures++; $display("FAIL pass_slt_zero got=%b exp=0", ext_zero0); end
        checks++; if (ext_y1 !== 32'd1 || ext_zero1 !== 1'b0) begin failures++; $display("FAIL pass_dut1 got=%h/%b exp=1/0", ext_y1, ext_zero1); end
        ext_a = 32'd0; ext_b = 32'd0; ext_f = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dc, dn, bc, oe;
        logic [W-1:0] pr;
        run_mul(1'b0, 32'd7, 32'd6, dc, dn, bc, oe, pr);
        checks++; if (dc !== 33) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=33", dc); end
        checks++; if (dn !== 1)  begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", dn); end
        checks++; if (bc !== 33) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=33", bc); end
        checks++; if (oe !== 0)  begin failures++; $display("FAIL basic_alu_ownership got=%0d exp=0", oe); end
        checks++; if (pr !== 32'h0000_002A) begin failures++; $display("FAIL basic_product got=%h exp=0000002a", pr); end
        checks++; if (product0 !== 32'h0000_002A) begin failures++; $display("FAIL basic_product_held got=%h exp=0000002a", product0); end
    endtask

    task automatic test_operands();
        int dc, dn, bc, oe;
        logic [W-1:0] pr;
        run_mul(1'b0, 32'hFFFF_FFFD, 32'd5, dc, dn, bc, oe, pr);
        checks++; if (pr !== 32'hFFFF_FFF1 || dc !== 33) begin failures++; $display("FAIL neg3x5 got=%h@%0d exp=fffffff1@33", pr, dc); end
        run_mul(1'b0, 32'h0001_0000, 32'h0001_0000, dc, dn, bc, oe, pr);
        checks++; if (pr !== 32'h0000_0000 || dc !== 33) begin failures++; $display("FAIL wrap got=%h@%0d exp=00000000@33", pr, dc); end
        run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, dn, bc, oe, pr);
        checks++; if (pr !== 32'h0000_0001) begin failures++; $display("FAIL ones got=%h exp=00000001", pr); end
        run_mul(1'b0, 32'h1234_5678, 32'h0000_0100, dc, dn, bc, oe, pr);
        checks++; if (pr !== 32'h3456_7800) begin failures++; $display("FAIL shift8 got=%h exp=34567800", pr); end
    endtask

    task automatic test_back_to_back();
        int dc;
        mul_a = 32'd7; mul_b = 32'd6; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 10) begin start0 = 1'b1; mul_a = 32'd100; mul_b = 32'd100; end
            if (c == 11) begin start0 = 1'b0; mul_a = 32'd7; mul_b = 32'd6; end
            if (c < 33) begin @(posedge clk); #1; end
        end
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done0); end
        checks++; if (product0 !== 32'd42) begin failures++; $display("FAIL b2b_product got=%h exp=0000002a", product0); end
        start0 = 1'b1; mul_a = 32'd100; mul_b = 32'd100;
        @(posedge clk); #1;
        checks++; if (busy0 !== 1'b0 || grant0 !== 1'b1) begin failures++; $display("FAIL b2b_start_in_done got=%b/%b exp=0/1", busy0, grant0); end
        mul_a = 32'd3; mul_b = 32'd4;
        @(posedge clk); #1;
        start0 = 1'b0;
        dc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done0 && dc == 0) dc = c;
            if (dc == 0) begin @(posedge clk); #1; end
        end
        checks++; if (dc !== 33) begin failures++; $display("FAIL b2b_second_done got=%0d exp=33", dc); end
        checks++; if (product0 !== 32'd12) begin failures++; $display("FAIL b2b_second_product got=%h exp=0000000c", product0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int dn, dc, bc, oe;
        logic [W-1:0] pr;
        mul_a = 32'd7; mul_b = 32'd6; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy0); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy0 !== 1'b0 || grant0 !== 1'b1) begin failures++; $display("FAIL rst_mid_state got=%b/%b exp=0/1", busy0, grant0); end
        checks++; if (product0 !== 32'h0) begin failures++; $display("FAIL rst_mid_product got=%h exp=0", product0); end
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (done0) dn++;
            @(posedge clk); #1;
        end
        checks++; if (dn !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", dn); end
        run_mul(1'b0, 32'd9, 32'd9, dc, dn, bc, oe, pr);
        checks++; if (pr !== 32'd81 || dc !== 33) begin failures++; $display("FAIL rst_mid_recover got=%h@%0d exp=00000051@33", pr, dc); end
    endtask

    task automatic test_early_exit();
        int dc, dn, bc, oe;
        logic [W-1:0] pr;
        run_mul(1'b1, 32'd9, 32'd4, dc, dn, bc, oe, pr);
        checks++; if (dc !== 4)  begin failures++; $display("FAIL ee_9x4_done got=%0d exp=4", dc); end
        checks++; if (bc !== 4)  begin failures++; $display("FAIL ee_9x4_busy got=%0d exp=4", bc); end
        checks++; if (pr !== 32'd36) begin failures++; $display("FAIL ee_9x4_product got=%h exp=00000024", pr); end
        checks++; if (dn !== 1 || oe !== 0) begin failures++; $display("FAIL ee_9x4_pulse got=%0d/%0d exp=1/0", dn, oe); end
        run_mul(1'b1, 32'd5, 32'd0, dc, dn, bc, oe, pr);
        checks++; if (dc !== 2 || pr !== 32'd0) begin failures++; $display("FAIL ee_b0 got=%h@%0d exp=00000000@2", pr, dc); end
        run_mul(1'b1, 32'd3, 32'h8000_0000, dc, dn, bc, oe, pr);
        checks++; if (dc !== 33 || pr !== 32'h8000_0000) begin failures++; $display("FAIL ee_msb got=%h@%0d exp=80000000@33", pr, dc); end
        run_mul(1'b1, 32'd11, 32'd1, dc, dn, bc, oe, pr);
        checks++; if (dc !== 2 || pr !== 32'd11) begin failures++; $display("FAIL ee_b1 got=%h@%0d exp=0000000b@2", pr, dc); end
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        mul_a = 32'd0; mul_b = 32'd0;
        ext_a = 32'd0; ext_b = 32'd0; ext_f = 3'b000;
        test_reset();
        test_passthrough();
        test_basic();
        test_operands();
        test_back_to_back();
        test_reset_mid_run();
        test_early_exit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
